alu_operand_regfile: RTL and testbench
======================================

// Module: alu_operand_regfile
// PURPOSE
//  Operand register file feeding the ALU. Holds four general-purpose registers (R1-R4)
//  and four scratch registers (S1-S4). Two independent read ports drive ALU InA/InB.
//  A shared write function updates any subset of registers on each clock edge.
//  Typical source of I: ALU Out fed back, or an external bus (memory / immediate).
// PARAMETERS
//  WIDTH        32   register and data width; must equal ALU operand width
//  RESET_VALUE  0    value loaded into every register on reset
// PORTS
//  clock     in   1      rising-edge clock
//  reset     in   1      asynchronous, active-high; clears all registers
//  I         in   WIDTH  write data
//  FunSel    in   3      write function applied to selected registers (see BEHAVIOUR)
//  RegSel    in   4      one bit per R1..R4 (bit0=R1); 1 = register updated this edge
//  ScrSel    in   4      one bit per S1..S4 (bit0=S1); 1 = register updated this edge
//  OutASel   in   3      read select A: 0-3 = R1-R4, 4-7 = S1-S4
//  OutBSel   in   3      read select B: same encoding as OutASel
//  OutA      out  WIDTH  read port A -> ALU InA
//  OutB      out  WIDTH  read port B -> ALU InB
// BEHAVIOUR
//  - Storage: 8 x WIDTH flops. The clock is ungated; registers not selected hold their value.
//  - Reset: asserting reset immediately sets all 8 registers to RESET_VALUE, independent
//    of clock. OutA/OutB therefore equal RESET_VALUE during reset and after it.
//  - Deasserting reset: the first write takes effect on the first rising edge with
//    reset low.
//  - Reset mid-operation: a write pending on the same edge as reset is discarded.
//  - Write (rising edge, reset low): each register with its RegSel/ScrSel bit set gets
//    f(own current value, I):
//      000  decrement        Q <= Q - 1 (mod 2^WIDTH; 0 -> all ones)
//      001  increment        Q <= Q + 1 (mod 2^WIDTH; all ones -> 0)
//      010  load             Q <= I
//      011  clear            Q <= 0
//      100  load byte        Q <= {0, I[7:0]}
//      101  load half        Q <= {0, I[15:0]}
//      110  shift-byte load  Q <= {Q[WIDTH-9:0], I[7:0]}
//      111  sign-ext half    Q <= {{(WIDTH-16){I[15]}}, I[15:0]}
//  - Multiple selected registers: each is updated independently from its own old value.
//    For example, inc with R1=5 and S2=9 gives R1=6 and S2=10 on the same edge.
//  - All select bits zero: no register changes, whatever FunSel is.
//  - Read: OutA/OutB are purely combinational muxes of the current register contents.
//  - Read latency: 0 cycles for stored data. A write is visible on OutA/OutB only after
//    the edge that performs it; there is no write-to-read bypass.
//  - Same-register reads: OutASel == OutBSel is legal; both ports show the same value.
//  - Read/write same cycle: reading a register being written in that cycle returns the
//    OLD value until the edge.
//  - Invalid encodings: none; all FunSel and OutXSel codes are defined.
//  - No X propagation from unselected registers.
// TESTING
//  1. Async reset: preload R2=0x1234 with load; pulse reset between clock edges ->
//     OutA (sel 1) reads 0 before the next edge.
//  2. Load/read: I=0xDEADBEEF, FunSel=010, RegSel=0001; OutASel=0, OutBSel=0 ->
//     both ports 0xDEADBEEF after one edge, 0 before it.
//  3. Wrap-around: S4=0xFFFFFFFF, inc -> 0x00000000; then dec -> 0xFFFFFFFF.
//  4. Multi-select: R1=5, R3=7, S1=0; FunSel=001, RegSel=0101, ScrSel=0001 ->
//     R1=6, R3=8, S1=1; R2/R4/S2-S4 unchanged.
//  5. Partial loads: I=0xABCD8F12 with FunSel=100 -> 0x00000012; 101 -> 0x00008F12;
//     111 -> 0xFFFF8F12. Then Q=0x11223344, I=0x55, FunSel=110 -> 0x22334455.
//  6. No bypass: load R4=0x77 while OutASel=3 -> OutA shows the old R4 until the edge,
//     then 0x77. Also check RegSel=ScrSel=0 with FunSel=011 -> no change.

Source files
------------

// File: rtl/alu_operand_regfile.sv
// Operand register file for the ALU: four general (R1-R4) and four scratch (S1-S4) registers,
// two combinational read ports, and one shared write function applied to any register subset.
module alu_operand_regfile #(
  parameter int unsigned           Width      = 32,
  parameter logic [Width-1:0]      ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] data_i,
  input  logic [2:0]       fun_sel_i,
  input  logic [3:0]       reg_sel_i,
  input  logic [3:0]       scr_sel_i,
  input  logic [2:0]       out_a_sel_i,
  input  logic [2:0]       out_b_sel_i,
  output logic [Width-1:0] out_a_o,
  output logic [Width-1:0] out_b_o
);

  typedef enum logic [2:0] {
    FunDec      = 3'b000,
    FunInc      = 3'b001,
    FunLoad     = 3'b010,
    FunClear    = 3'b011,
    FunLoadByte = 3'b100,
    FunLoadHalf = 3'b101,
    FunShiftIn  = 3'b110,
    FunSextHalf = 3'b111
  } fun_e;

  // Index 0-3 = R1-R4, 4-7 = S1-S4; matches the read-select encoding directly.
  logic [Width-1:0] regs_q [8];
  logic [Width-1:0] regs_d [8];
  logic [7:0]       wr_en;

  assign wr_en = {scr_sel_i, reg_sel_i};

  function automatic logic [Width-1:0] apply_fun(input fun_e             fun,
                                                 input logic [Width-1:0] q,
                                                 input logic [Width-1:0] d);
    logic [Width-1:0] r;
    r = q;
    unique case (fun)
      FunDec:      r = q - Width'(1);
      FunInc:      r = q + Width'(1);
      FunLoad:     r = d;
      FunClear:    r = '0;
      FunLoadByte: r = Width'(d[7:0]);
      FunLoadHalf: r = Width'(d[15:0]);
      FunShiftIn:  r = (q << 8) | Width'(d[7:0]);
      FunSextHalf: r = Width'(signed'(d[15:0]));
      default:     r = q;
    endcase
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en[i]) begin
        regs_d[i] = apply_fun(fun_e'(fun_sel_i), regs_q[i], data_i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= ResetValue;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign out_a_o = regs_q[out_a_sel_i];
  assign out_b_o = regs_q[out_b_sel_i];

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Directed bench for alu_operand_regfile: expected read values are queued when a check is set
// up and popped when the read ports are sampled.
module tb_alu_operand_regfile;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] data_i;
  logic [2:0]  fun_sel_i;
  logic [3:0]  reg_sel_i;
  logic [3:0]  scr_sel_i;
  logic [2:0]  out_a_sel_i;
  logic [2:0]  out_b_sel_i;
  logic [31:0] out_a_o;
  logic [31:0] out_b_o;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] model [8];
  string       tag_q [$];
  logic [31:0] exp_a_q [$];
  logic [31:0] exp_b_q [$];

  alu_operand_regfile #(
    .Width     (32),
    .ResetValue(32'h0)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .fun_sel_i  (fun_sel_i),
    .reg_sel_i  (reg_sel_i),
    .scr_sel_i  (scr_sel_i),
    .out_a_sel_i(out_a_sel_i),
    .out_b_sel_i(out_b_sel_i),
    .out_a_o    (out_a_o),
    .out_b_o    (out_b_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] ref_fun(input logic [2:0] fun, input logic [31:0] q,
                                          input logic [31:0] d);
    case (fun)
      3'd0:    return q - 32'd1;
      3'd1:    return q + 32'd1;
      3'd2:    return d;
      3'd3:    return 32'd0;
      3'd4:    return {24'd0, d[7:0]};
      3'd5:    return {16'd0, d[15:0]};
      3'd6:    return {q[23:0], d[7:0]};
      default: return {{16{d[15]}}, d[15:0]};
    endcase
  endfunction

  // Set read selects and queue the expected port values.
  task automatic expect_rd(input string tag, input logic [2:0] sa, input logic [2:0] sb,
                           input logic [31:0] ea, input logic [31:0] eb);
    out_a_sel_i = sa;
    out_b_sel_i = sb;
    tag_q.push_back(tag);
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
  endtask

  // Let the read mux settle, then pop and compare.
  task automatic check_out();
    string       tag;
    logic [31:0] ea;
    logic [31:0] eb;
    #1;
    tag = tag_q.pop_front();
    ea  = exp_a_q.pop_front();
    eb  = exp_b_q.pop_front();
    n_checks++;
    assert (out_a_o === ea) else begin
      n_fails++;
      $error("FAIL %s OutA: got %h expected %h", tag, out_a_o, ea);
    end
    n_checks++;
    assert (out_b_o === eb) else begin
      n_fails++;
      $error("FAIL %s OutB: got %h expected %h", tag, out_b_o, eb);
    end
  endtask

  task automatic rd(input string tag, input logic [2:0] sa, input logic [2:0] sb,
                    input logic [31:0] ea, input logic [31:0] eb);
    expect_rd(tag, sa, sb, ea, eb);
    check_out();
  endtask

  task automatic rd_model_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd(tag, 3'(i), 3'(7 - i), model[i], model[7 - i]);
    end
  endtask

  // Present a write in the low phase so checks can run before the edge commits it.
  task automatic drive_write(input logic [2:0] fun, input logic [3:0] rs, input logic [3:0] ss,
                             input logic [31:0] d);
    @(negedge clk_i);
    fun_sel_i = fun;
    reg_sel_i = rs;
    scr_sel_i = ss;
    data_i    = d;
  endtask

  task automatic commit();
    logic [7:0] en;
    @(posedge clk_i);
    #1;
    en = {scr_sel_i, reg_sel_i};
    for (int i = 0; i < 8; i++) begin
      if (en[i]) model[i] = ref_fun(fun_sel_i, model[i], data_i);
    end
    reg_sel_i = 4'd0;
    scr_sel_i = 4'd0;
  endtask

  task automatic wr(input logic [2:0] fun, input logic [3:0] rs, input logic [3:0] ss,
                    input logic [31:0] d);
    drive_write(fun, rs, ss, d);
    commit();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = 32'd0;
    rst_i       = 1'b1;
    data_i      = 32'd0;
    fun_sel_i   = 3'd0;
    reg_sel_i   = 4'd0;
    scr_sel_i   = 4'd0;
    out_a_sel_i = 3'd0;
    out_b_sel_i = 3'd0;

    rd_model_all("reset_state");
    @(negedge clk_i);
    rst_i = 1'b0;

    // Async reset between edges.
    wr(3'd2, 4'b0010, 4'b0000, 32'h0000_1234);
    rd("preload_r2", 3'd1, 3'd1, 32'h0000_1234, 32'h0000_1234);
    #2;
    rst_i = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = 32'd0;
    rd("async_rst_during", 3'd1, 3'd1, 32'd0, 32'd0);
    rst_i = 1'b0;
    rd("async_rst_after", 3'd1, 3'd0, 32'd0, 32'd0);

    // Write pending on an edge taken under reset is dropped.
    drive_write(3'd2, 4'b0001, 4'b0000, 32'h5555_AAAA);
    rst_i = 1'b1;
    commit();
    model[0] = 32'd0;
    rst_i = 1'b0;
    rd("rst_drops_write", 3'd0, 3'd0, 32'd0, 32'd0);

    // Load/read with no write-to-read bypass.
    drive_write(3'd2, 4'b0001, 4'b0000, 32'hDEAD_BEEF);
    rd("load_before_edge", 3'd0, 3'd0, 32'd0, 32'd0);
    commit();
    rd("load_after_edge", 3'd0, 3'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Wrap-around on S4.
    wr(3'd2, 4'b0000, 4'b1000, 32'hFFFF_FFFF);
    wr(3'd1, 4'b0000, 4'b1000, 32'd0);
    rd("inc_wrap", 3'd7, 3'd0, 32'h0000_0000, 32'hDEAD_BEEF);
    wr(3'd0, 4'b0000, 4'b1000, 32'd0);
    rd("dec_wrap", 3'd7, 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Multi-select increment, each register from its own old value.
    wr(3'd2, 4'b0001, 4'b0000, 32'd5);
    wr(3'd2, 4'b0100, 4'b0000, 32'd7);
    wr(3'd3, 4'b0000, 4'b0001, 32'hFFFF_FFFF);
    wr(3'd1, 4'b0101, 4'b0001, 32'h1234_5678);
    rd("multi_r1_r3", 3'd0, 3'd2, 32'd6, 32'd8);
    rd("multi_s1_r2", 3'd4, 3'd1, 32'd1, 32'd0);
    rd("multi_r4_s4", 3'd3, 3'd7, 32'd0, 32'hFFFF_FFFF);
    rd_model_all("multi_all");

    // Partial loads into S2.
    wr(3'd4, 4'b0000, 4'b0010, 32'hABCD_8F12);
    rd("load_byte", 3'd5, 3'd5, 32'h0000_0012, 32'h0000_0012);
    wr(3'd5, 4'b0000, 4'b0010, 32'hABCD_8F12);
    rd("load_half", 3'd5, 3'd4, 32'h0000_8F12, 32'd1);
    wr(3'd7, 4'b0000, 4'b0010, 32'hABCD_8F12);
    rd("sext_neg", 3'd5, 3'd5, 32'hFFFF_8F12, 32'hFFFF_8F12);
    wr(3'd7, 4'b0000, 4'b0010, 32'hFFFF_7FFF);
    rd("sext_pos", 3'd5, 3'd5, 32'h0000_7FFF, 32'h0000_7FFF);
    wr(3'd2, 4'b0000, 4'b0010, 32'h1122_3344);
    wr(3'd6, 4'b0000, 4'b0010, 32'h0000_0055);
    rd("shift_byte", 3'd5, 3'd0, 32'h2233_4455, 32'd6);

    // No bypass on R4 while it is being read.
    drive_write(3'd2, 4'b1000, 4'b0000, 32'h0000_0077);
    rd("r4_old", 3'd3, 3'd3, 32'd0, 32'd0);
    commit();
    rd("r4_new", 3'd3, 3'd3, 32'h0000_0077, 32'h0000_0077);

    // Clear with no selects changes nothing.
    drive_write(3'd3, 4'b0000, 4'b0000, 32'd0);
    commit();
    rd_model_all("no_select");

    // Load into every register at once, then decrement all.
    wr(3'd2, 4'b1111, 4'b1111, 32'h8000_0000);
    wr(3'd0, 4'b1111, 4'b1111, 32'd0);
    rd("all_dec", 3'd0, 3'd6, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    rd_model_all("all_dec_model");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
